// File: rtl/addsub_bist.sv
// addsub_bist
//
// Built-in self test sequencer for a 2-bit adder/subtractor. On a start
// request it sweeps all 32 combinations of {a1,a0,b1,b0,Cin}, lets each
// vector settle, captures the returned T bit into a 32-bit response word
// and compares the result against a golden signature.
//
// Optional feature macro: ADDSUB_BIST_ERRCNT_EN
//   defined   -> err_cnt counts per-bit mismatches against EXP_RESP
//                (saturating at 32, cleared on sweep start)
//   undefined -> err_cnt is tied to zero and no counter is built
//
// Parameters:
//   SETTLE_CYCLES  cycles a vector is held before its response is sampled (1..15)
//   EXP_RESP       golden 32-bit response signature
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            one-cycle sweep request, honoured only while idle
//   t_in             T output returned by the unit under test
//   a0,a1,b0,b1,Cin  registered stimulus bits
//   busy             high while a sweep is running
//   done             one-cycle pulse when a sweep completes
//   pass             last completed sweep matched EXP_RESP (held until next start)
//   resp             captured response, resp[i] = t_in for vector i
//   err_cnt          mismatch count between resp and EXP_RESP

module addsub_bist #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter logic [31:0] EXP_RESP      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        t_in,
   output logic        a0,
   output logic        a1,
   output logic        b0,
   output logic        b1,
   output logic        Cin,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] resp,
   output logic [5:0]  err_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      FIN
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [3:0]  settle_q, settle_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [31:0] resp_q, resp_d;

   // Sweep sequencing. The vector index doubles as the stimulus register,
   // so it is parked at zero whenever the block is not sweeping. The pass
   // verdict is taken from resp_d so the last sampled bit is included and
   // the verdict appears together with the done pulse.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      resp_d   = resp_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = DRIVE;
               idx_d    = 5'd0;
               settle_d = 4'd0;
               resp_d   = 32'd0;
               pass_d   = 1'b0;
               busy_d   = 1'b1;
            end
         end
         DRIVE: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = 4'd0;
               state_d  = SAMPLE;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         SAMPLE: begin
            resp_d[idx_q] = t_in;
            if (idx_q == 5'd31) begin
               state_d = FIN;
               idx_d   = 5'd0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               pass_d  = (resp_d == EXP_RESP);
            end else begin
               idx_d   = idx_q + 5'd1;
               state_d = DRIVE;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= 5'd0;
         settle_q <= 4'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         resp_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         resp_q   <= resp_d;
      end
   end

`ifdef ADDSUB_BIST_ERRCNT_EN
   logic [5:0] err_q, err_d;

   // Mismatch counter, evaluated against the golden bit of the vector
   // being sampled; it stops at 32, which is also the largest possible count.
   always_comb begin
      err_d = err_q;
      if (state_q == IDLE && start) begin
         err_d = 6'd0;
      end else if (state_q == SAMPLE) begin
         if ((t_in != EXP_RESP[idx_q]) && (err_q != 6'd32)) begin
            err_d = err_q + 6'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 6'd0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 6'd0;
`endif

   assign {a1, a0, b1, b0, Cin} = idx_q;
   assign busy = busy_q;
   assign done = done_q;
   assign pass = pass_q;
   assign resp = resp_q;

endmodule

// File: tb/tb_addsub_bist.sv
// tb_addsub_bist
//
// Self-checking bench for addsub_bist. Three instances share clock and
// reset: u0 (SETTLE=1, golden 0) with a selectable T model, u1 (SETTLE=1,
// golden AAAA_AAAA) whose T follows Cin, and u2 (SETTLE=3, golden
// FFFF_0000) whose T follows a1.

module tb_addsub_bist;

`ifdef ADDSUB_BIST_ERRCNT_EN
   localparam logic [5:0] ERR_ALL  = 6'd32;
   localparam logic [5:0] ERR_HALF = 6'd16;
`else
   localparam logic [5:0] ERR_ALL  = 6'd0;
   localparam logic [5:0] ERR_HALF = 6'd0;
`endif

   logic        clk;
   logic        rst_n;
   logic        startS [3];
   logic        tIn    [3];
   logic        a0W    [3];
   logic        a1W    [3];
   logic        b0W    [3];
   logic        b1W    [3];
   logic        cinW   [3];
   logic        busyW  [3];
   logic        doneW  [3];
   logic        passW  [3];
   logic [31:0] respW  [3];
   logic [5:0]  errW   [3];
   logic [4:0]  stim   [3];

   int total;
   int bad;
   int tMode;
   int steps;
   int orderBad;
   logic [4:0] prevStim;

   typedef struct {
      int          mode;
      logic [31:0] resp;
      logic        pass;
      logic [5:0]  err;
   } vec_t;

   vec_t vecs [4];

   addsub_bist #(.SETTLE_CYCLES(1), .EXP_RESP(32'h0000_0000)) u0 (
      .clk(clk), .rst_n(rst_n), .start(startS[0]), .t_in(tIn[0]),
      .a0(a0W[0]), .a1(a1W[0]), .b0(b0W[0]), .b1(b1W[0]), .Cin(cinW[0]),
      .busy(busyW[0]), .done(doneW[0]), .pass(passW[0]),
      .resp(respW[0]), .err_cnt(errW[0])
   );

   addsub_bist #(.SETTLE_CYCLES(1), .EXP_RESP(32'hAAAA_AAAA)) u1 (
      .clk(clk), .rst_n(rst_n), .start(startS[1]), .t_in(tIn[1]),
      .a0(a0W[1]), .a1(a1W[1]), .b0(b0W[1]), .b1(b1W[1]), .Cin(cinW[1]),
      .busy(busyW[1]), .done(doneW[1]), .pass(passW[1]),
      .resp(respW[1]), .err_cnt(errW[1])
   );

   addsub_bist #(.SETTLE_CYCLES(3), .EXP_RESP(32'hFFFF_0000)) u2 (
      .clk(clk), .rst_n(rst_n), .start(startS[2]), .t_in(tIn[2]),
      .a0(a0W[2]), .a1(a1W[2]), .b0(b0W[2]), .b1(b1W[2]), .Cin(cinW[2]),
      .busy(busyW[2]), .done(doneW[2]), .pass(passW[2]),
      .resp(respW[2]), .err_cnt(errW[2])
   );

   // T models for the three units under test
   assign tIn[0] = (tMode == 0) ? 1'b0 : (tMode == 1) ? 1'b1 : cinW[0];
   assign tIn[1] = cinW[1];
   assign tIn[2] = a1W[2];

   assign stim[0] = {a1W[0], a0W[0], b1W[0], b0W[0], cinW[0]};
   assign stim[1] = {a1W[1], a0W[1], b1W[1], b0W[1], cinW[1]};
   assign stim[2] = {a1W[2], a0W[2], b1W[2], b0W[2], cinW[2]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watches u0's stimulus during a sweep: every change must be a +1 step
   always @(negedge clk) begin
      if (busyW[0]) begin
         if (stim[0] != prevStim) begin
            if (stim[0] == prevStim + 5'd1) steps++;
            else orderBad++;
         end
         prevStim = stim[0];
      end else begin
         prevStim = 5'd0;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Pulses start for unit u, optionally re-pulses start when the stimulus
   // reaches midIdx, and returns the edge count from the start edge to done.
   task automatic applyStimulus(input int u, input int midIdx, output int cycles);
      bit pulsed;
      pulsed = 0;
      cycles = 0;
      @(negedge clk);
      startS[u] = 1'b1;
      @(posedge clk);
      #1;
      startS[u] = 1'b0;
      steps = 0;
      orderBad = 0;
      checkOutput($sformatf("u%0d busy at start", u), 32'(busyW[u]), 32'd1);
      checkOutput($sformatf("u%0d pass cleared", u), 32'(passW[u]), 32'd0);
      checkOutput($sformatf("u%0d resp cleared", u), respW[u], 32'd0);
      checkOutput($sformatf("u%0d first vector", u), 32'(stim[u]), 32'd0);
      while (doneW[u] !== 1'b1 && cycles < 1000) begin
         if (midIdx >= 0 && !pulsed && stim[u] == 5'(midIdx)) begin
            startS[u] = 1'b1;
            pulsed = 1;
         end
         @(posedge clk);
         #1;
         startS[u] = 1'b0;
         cycles++;
      end
      checkOutput($sformatf("u%0d busy low with done", u), 32'(busyW[u]), 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("u%0d done one cycle", u), 32'(doneW[u]), 32'd0);
   endtask

   task automatic waitStim(input int u, input logic [4:0] val, output bit ok);
      int n;
      n = 0;
      while (stim[u] != val && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      ok = (stim[u] == val);
   endtask

   int cyc;
   int dones;
   bit ok;

   initial begin
      total = 0;
      bad = 0;
      tMode = 0;
      steps = 0;
      orderBad = 0;
      prevStim = 5'd0;
      for (int i = 0; i < 3; i++) startS[i] = 1'b0;

      vecs[0] = '{mode: 0, resp: 32'h0000_0000, pass: 1'b1, err: 6'd0};
      vecs[1] = '{mode: 1, resp: 32'hFFFF_FFFF, pass: 1'b0, err: ERR_ALL};
      vecs[2] = '{mode: 2, resp: 32'hAAAA_AAAA, pass: 1'b0, err: ERR_HALF};
      vecs[3] = '{mode: 0, resp: 32'h0000_0000, pass: 1'b1, err: 6'd0};

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
         checkOutput($sformatf("u%0d reset stim", u), 32'(stim[u]), 32'd0);
         checkOutput($sformatf("u%0d reset flags", u),
                     {29'd0, busyW[u], doneW[u], passW[u]}, 32'd0);
         checkOutput($sformatf("u%0d reset resp", u), respW[u], 32'd0);
         checkOutput($sformatf("u%0d reset err", u), 32'(errW[u]), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Back-to-back table-driven sweeps on u0
      for (int i = 0; i < 4; i++) begin
         tMode = vecs[i].mode;
         applyStimulus(0, -1, cyc);
         checkOutput($sformatf("vec%0d latency", i), cyc, 32'd64);
         checkOutput($sformatf("vec%0d resp", i), respW[0], vecs[i].resp);
         checkOutput($sformatf("vec%0d pass", i), 32'(passW[0]), 32'(vecs[i].pass));
         checkOutput($sformatf("vec%0d err_cnt", i), 32'(errW[0]), 32'(vecs[i].err));
         checkOutput($sformatf("vec%0d steps", i), steps, 32'd31);
         checkOutput($sformatf("vec%0d order", i), orderBad, 32'd0);
      end

      // Golden signature follows Cin
      applyStimulus(1, -1, cyc);
      checkOutput("u1 latency", cyc, 32'd64);
      checkOutput("u1 resp", respW[1], 32'hAAAA_AAAA);
      checkOutput("u1 pass", 32'(passW[1]), 32'd1);
      checkOutput("u1 err_cnt", 32'(errW[1]), 32'd0);

      // Start re-pulsed mid-sweep must neither restart nor queue a sweep
      tMode = 0;
      applyStimulus(0, 10, cyc);
      checkOutput("midstart latency", cyc, 32'd64);
      dones = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (doneW[0] === 1'b1) dones++;
      end
      checkOutput("midstart extra done", dones, 32'd0);
      checkOutput("midstart idle", 32'(busyW[0]), 32'd0);
      checkOutput("midstart pass", 32'(passW[0]), 32'd1);

      // Reset in the middle of a sweep
      tMode = 1;
      @(negedge clk);
      startS[0] = 1'b1;
      @(posedge clk);
      #1;
      startS[0] = 1'b0;
      waitStim(0, 5'd17, ok);
      checkOutput("reach idx 17", 32'(ok), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset stim", 32'(stim[0]), 32'd0);
      checkOutput("async reset flags", {29'd0, busyW[0], doneW[0], passW[0]}, 32'd0);
      checkOutput("async reset resp", respW[0], 32'd0);
      checkOutput("async reset err", 32'(errW[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (doneW[0] === 1'b1) dones++;
      end
      checkOutput("post reset no done", dones, 32'd0);
      checkOutput("post reset idle", 32'(busyW[0]), 32'd0);
      applyStimulus(0, -1, cyc);
      checkOutput("post reset latency", cyc, 32'd64);
      checkOutput("post reset resp", respW[0], 32'hFFFF_FFFF);
      checkOutput("post reset err", 32'(errW[0]), 32'(ERR_ALL));
      checkOutput("post reset steps", steps, 32'd31);

      // Longer settle time, T follows a1
      applyStimulus(2, -1, cyc);
      checkOutput("u2 latency", cyc, 32'd128);
      checkOutput("u2 resp", respW[2], 32'hFFFF_0000);
      checkOutput("u2 pass", 32'(passW[2]), 32'd1);
      checkOutput("u2 err_cnt", 32'(errW[2]), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/addsub_bist.md
ADDSUB_BIST -- requirements
Module: addsub_bist

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: wait cycles between applying a vector and sampling the response (range 1..15).
REQ-002 Parameter EXP_RESP, default 32'h0000_0000: golden 32-bit response signature.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to run a full sweep; sampled in IDLE only.
REQ-006 t_in  input  1  T output returned from the 2-bit adder/subtractor under test.
REQ-007 a0, a1, b0, b1, Cin  output  1 each  stimulus bits driven to the adder/subtractor, all registered.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse when a sweep completes.
REQ-010 pass  output  1  high when the last completed sweep matched EXP_RESP; held until the next start.
REQ-011 resp  output  32  captured response vector; resp[i] is t_in sampled for vector index i.
REQ-012 err_cnt  output  6  number of bit mismatches between resp and EXP_RESP (see Configuration).

Function
REQ-013 FSM states: IDLE, DRIVE, SAMPLE, FIN. Encoding is free.
REQ-014 IDLE with start=1 -> DRIVE; idx<=0; resp<=0; err_cnt<=0; pass<=0; busy<=1 on the next edge.
REQ-015 5-bit vector index idx maps to the stimulus as {a1,a0,b1,b0,Cin} = idx; outputs update on the edge that enters DRIVE.
REQ-016 DRIVE holds the stimulus for SETTLE_CYCLES cycles using a settle counter, then -> SAMPLE.
REQ-017 SAMPLE: resp[idx]<=t_in; stimulus unchanged; idx==31 -> FIN, else idx<=idx+1 -> DRIVE.
REQ-018 Per-vector cost is SETTLE_CYCLES+1 cycles; start-to-done latency is 32*(SETTLE_CYCLES+1)+1 cycles.
REQ-019 FIN: done=1 for exactly one cycle; pass<=(resp==EXP_RESP), using the final sampled bit; busy<=0; -> IDLE.
REQ-020 idx does not wrap within a sweep; exactly 32 samples are taken per sweep.
REQ-021 start asserted while busy=1 or in FIN is ignored, and no second sweep is queued.
REQ-022 start on the cycle after done begins a new sweep normally.
REQ-023 In IDLE the stimulus outputs hold 0; resp and pass hold their last values.

Reset
REQ-024 When rst_n=0, the block immediately enters IDLE, irrespective of clk.
REQ-025 Reset values: a0=a1=b0=b1=Cin=0, busy=0, done=0, pass=0, resp=0, err_cnt=0, idx=0, settle counter=0.
REQ-026 Reset during a sweep aborts it with no done pulse; after release the block waits in IDLE for start.

Configuration
REQ-027 Macro ADDSUB_BIST_ERRCNT_EN defined: in each SAMPLE, err_cnt increments when t_in != EXP_RESP[idx]; it saturates at 32 and is cleared on sweep start.
REQ-028 Macro ADDSUB_BIST_ERRCNT_EN undefined: err_cnt is tied to 0 and no counter logic is built; all other behaviour is identical.

Verification
REQ-029 SETTLE_CYCLES=1, EXP_RESP=0, t_in tied 0, pulse start -> done at cycle 65 after start; resp=0; pass=1; err_cnt=0.
REQ-030 t_in tied 1, EXP_RESP=0, with the macro defined -> resp=32'hFFFF_FFFF, pass=0, err_cnt=32.
REQ-031 t_in driven by a model that returns Cin, EXP_RESP=32'hAAAA_AAAA -> pass=1; stimulus steps 00000..11111 in order; without the macro, err_cnt=0.
REQ-032 Pulse start again at idx=10 mid-sweep -> no restart; exactly one done pulse; total latency unchanged.
REQ-033 Deassert rst_n at idx=17 -> all outputs reach reset values at once, with no done pulse; a fresh start then completes a full 32-vector sweep.
REQ-034 SETTLE_CYCLES=3, t_in model returning a1 -> done 129 cycles after start; resp=32'hFFFF_0000.
